// File: rtl/sent_rx.sv
// SENT (SAE J2716) frame receiver: measures falling-edge intervals in ticks,
// checks sync/nibble ranges and CRC, and emits each frame as one 32-bit word.
module sent_rx #(
  parameter int CHANNEL_INDEX = 0,
  parameter int CLK_FREQ      = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sent_config_vld,
  input  logic [7:0]  sent_config_channel,
  input  logic [7:0]  sent_ctick_len,
  input  logic        sent_crc_mode,
  input  logic        sent_in,
  output logic        sent_frame_vld,
  output logic [31:0] sent_frame_data,
  output logic        sent_crc_err,
  output logic        sent_err,
  output logic [1:0]  dbg_state
);

  localparam int          CLK_MHZ       = CLK_FREQ / 1000000;
  localparam logic [7:0]  CH            = 8'(CHANNEL_INDEX);
  localparam logic [13:0] RST_TICK_CLKS = 14'(3 * CLK_MHZ);
  localparam logic [9:0]  TICK_SAT      = 10'h3ff;
  localparam logic [3:0]  CRC_T [16]    = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                                            4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};

  typedef enum logic [1:0] {S_HUNT, S_STATUS, S_DATA, S_CRC} state_t;

  // Seed 5, fold D1..D6 (D1 in [23:20]); recommended mode adds a zero nibble.
  function automatic logic [3:0] crc_calc(input logic [23:0] d, input logic rec);
    logic [3:0] c;
    c = 4'h5;
    for (int i = 5; i >= 0; i--) c = CRC_T[c] ^ d[i*4 +: 4];
    if (rec) c = CRC_T[c];
    return c;
  endfunction

  state_t      state, state_nx;
  logic        s1, s2, prev;
  logic        fall, cfg_hit, round_up, timeout;
  logic [13:0] tick_clks, sub_cnt;
  logic [9:0]  tick_cnt;
  logic        crc_mode, first_armed;
  logic        meas_vld;
  logic [10:0] meas_ticks;
  logic        nib_ok, accept, frame_done, framing_err;
  logic [3:0]  nib;
  logic [2:0]  idx;
  logic [3:0]  status_q;
  logic [23:0] data_sr;
  logic        frame_pend, err_pend, pend_crc_err;
  logic [31:0] pend_word;

  assign fall      = prev & ~s2;
  assign cfg_hit   = sent_config_vld && (sent_config_channel == CH);
  // The edge cycle itself is part of the interval, hence the +1.
  assign round_up  = ({1'b0, sub_cnt} + 15'd1) >= {2'b00, tick_clks[13:1]};
  assign timeout   = (state != S_HUNT) && (tick_cnt == TICK_SAT);
  assign nib_ok    = (meas_ticks >= 11'd12) && (meas_ticks <= 11'd27);
  assign nib       = 4'(meas_ticks - 11'd12);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= sent_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Interval measurement; a matching config write outranks a coincident edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_clks   <= RST_TICK_CLKS;
      crc_mode    <= 1'b1;
      sub_cnt     <= '0;
      tick_cnt    <= '0;
      first_armed <= 1'b1;
      meas_vld    <= 1'b0;
      meas_ticks  <= '0;
    end else begin
      meas_vld <= 1'b0;
      if (cfg_hit) begin
        tick_clks   <= 14'(int'(sent_ctick_len) * CLK_MHZ);
        crc_mode    <= sent_crc_mode;
        sub_cnt     <= '0;
        tick_cnt    <= '0;
        first_armed <= ~fall;
      end else if (fall) begin
        meas_vld    <= ~first_armed;
        meas_ticks  <= {1'b0, tick_cnt} + {10'd0, round_up};
        first_armed <= 1'b0;
        sub_cnt     <= '0;
        tick_cnt    <= '0;
      end else if (sub_cnt >= tick_clks - 14'd1) begin
        sub_cnt <= '0;
        if (tick_cnt != TICK_SAT) tick_cnt <= tick_cnt + 10'd1;
      end else begin
        sub_cnt <= sub_cnt + 14'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    frame_done  = 1'b0;
    framing_err = 1'b0;
    if (cfg_hit || timeout) begin
      state_nx = S_HUNT;
    end else if (meas_vld) begin
      case (state)
        S_HUNT: if (meas_ticks == 11'd56) state_nx = S_STATUS;
        S_STATUS, S_DATA: begin
          if (nib_ok) begin
            accept = 1'b1;
            if (state == S_STATUS)  state_nx = S_DATA;
            else if (idx == 3'd5)   state_nx = S_CRC;
          end else begin
            framing_err = 1'b1;
            state_nx    = S_HUNT;
          end
        end
        S_CRC: begin
          state_nx = S_HUNT;
          if (nib_ok) frame_done  = 1'b1;
          else        framing_err = 1'b1;
        end
        default: state_nx = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      status_q     <= '0;
      data_sr      <= '0;
      frame_pend   <= 1'b0;
      err_pend     <= 1'b0;
      pend_word    <= '0;
      pend_crc_err <= 1'b0;
    end else begin
      frame_pend <= frame_done;
      err_pend   <= framing_err;
      if (accept) begin
        if (state == S_STATUS) begin
          status_q <= nib;
          idx      <= 3'd0;
        end else begin
          data_sr <= {data_sr[19:0], nib};
          idx     <= idx + 3'd1;
        end
      end
      if (frame_done) begin
        pend_word    <= {status_q, data_sr, nib};
        pend_crc_err <= (crc_calc(data_sr, crc_mode) != nib);
      end
    end
  end

  // sent_frame_vld is a one-cycle strobe with no backpressure; data and
  // crc_err hold until the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_frame_vld  <= 1'b0;
      sent_frame_data <= '0;
      sent_crc_err    <= 1'b0;
      sent_err        <= 1'b0;
    end else begin
      sent_frame_vld <= frame_pend;
      sent_err       <= err_pend | (timeout & ~cfg_hit);
      if (frame_pend) begin
        sent_frame_data <= pend_word;
        sent_crc_err    <= pend_crc_err;
      end
    end
  end

endmodule

// File: tb/tb_sent_rx.sv
// Bench for sent_rx: drives SENT waveforms at 6 clk/tick and scores decoded
// frames against a rounding/CRC reference model.
module tb_sent_rx;

  localparam int CLK_FREQ = 2000000;
  localparam int TC       = 6;
  localparam logic [3:0] CRC_T [16] = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                                        4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};

  logic        clk = 1'b0;
  logic        rst;
  logic        sent_config_vld;
  logic [7:0]  sent_config_channel;
  logic [7:0]  sent_ctick_len;
  logic        sent_crc_mode;
  logic        sent_in;
  logic        sent_frame_vld;
  logic [31:0] sent_frame_data;
  logic        sent_crc_err;
  logic        sent_err;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  bit          cur_rec = 1'b1;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  sent_rx #(.CHANNEL_INDEX(0), .CLK_FREQ(CLK_FREQ)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sent_config_vld     (sent_config_vld),
    .sent_config_channel (sent_config_channel),
    .sent_ctick_len      (sent_ctick_len),
    .sent_crc_mode       (sent_crc_mode),
    .sent_in             (sent_in),
    .sent_frame_vld      (sent_frame_vld),
    .sent_frame_data     (sent_frame_data),
    .sent_crc_err        (sent_crc_err),
    .sent_err            (sent_err),
    .dbg_state           (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sent_frame_vld) got_q.push_back({sent_crc_err, sent_frame_data});
    if (sent_err) err_seen++;
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rounded(input int n);
    return (n + TC / 2) / TC;
  endfunction

  function automatic logic [3:0] crc_ref(input logic [23:0] d, input bit rec);
    logic [3:0] c;
    c = 4'h5;
    for (int i = 0; i < 6; i++) c = CRC_T[c] ^ d[(5 - i) * 4 +: 4];
    if (rec) c = CRC_T[c];
    return c;
  endfunction

  // One edge-to-edge interval of n clocks; optional config strobe in the low phase.
  task automatic pulse(input int n, input bit do_cfg);
    int lo;
    lo = n / 3;
    sent_in = 1'b0;
    if (do_cfg) begin
      @(negedge clk);
      sent_config_vld = 1'b1;
      @(negedge clk);
      sent_config_vld = 1'b0;
      lo -= 2;
    end
    repeat (lo) @(negedge clk);
    sent_in = 1'b1;
    repeat (n - n / 3) @(negedge clk);
  endtask

  task automatic pause(input int ticks);
    pulse(ticks * TC, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] ch, input logic [7:0] len, input bit rec);
    sent_config_vld     = 1'b1;
    sent_config_channel = ch;
    sent_ctick_len      = len;
    sent_crc_mode       = rec;
    @(negedge clk);
    sent_config_vld = 1'b0;
    if (ch == 8'd0) cur_rec = rec;
  endtask

  task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc,
                            input int sync_n, input int st_extra, input bit jit, input int cfg_at);
    logic [3:0]  nib [8];
    logic [3:0]  got [8];
    logic [23:0] dd;
    int          n;
    bit          ok;
    nib[0] = st;
    for (int i = 0; i < 6; i++) nib[i + 1] = d[(5 - i) * 4 +: 4];
    nib[7] = crc;
    ok = (rounded(sync_n) == 56);
    if (cfg_at >= 0 && sent_config_channel == 8'd0) begin
      ok = 1'b0;
      cur_rec = sent_crc_mode;
    end
    pulse(sync_n, cfg_at == 0);
    for (int i = 0; i < 8; i++) begin
      n = (int'(nib[i]) + 12) * TC;
      if (i == 0) n += st_extra;
      if (jit) n += int'($urandom_range(0, TC - 1)) - TC / 2;
      got[i] = 4'(rounded(n) - 12);
      pulse(n, cfg_at == i + 1);
    end
    if (ok) begin
      dd = {got[1], got[2], got[3], got[4], got[5], got[6]};
      exp_q.push_back({crc_ref(dd, cur_rec) != got[7], got[0], dd, got[7]});
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, 33'(got_q.size()), 33'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_errs"}, 33'(err_seen), 33'(exp_err));
  endtask

  initial begin
    logic [3:0]  st;
    logic [23:0] d;
    logic [3:0]  c;

    rst = 1'b1;
    sent_in = 1'b1;
    sent_config_vld = 1'b0;
    sent_config_channel = 8'd0;
    sent_ctick_len = 8'd3;
    sent_crc_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld", 33'(sent_frame_vld), 33'd0);
    check("rst_data", 33'(sent_frame_data), 33'd0);
    check("rst_crc_err", 33'(sent_crc_err), 33'd0);
    check("rst_err", 33'(sent_err), 33'd0);
    check("rst_state", 33'(dbg_state), 33'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal frame in recommended mode, with exact output latency
    send_frame(4'h0, 24'h123456, 4'h2, 56 * TC, 0, 1'b0, -1);
    sent_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("lat_e3", 33'(sent_frame_vld), 33'd0);
    @(posedge clk);
    #1 check("lat_e4", 33'(sent_frame_vld), 33'd1);
    @(posedge clk);
    #1 check("lat_e5", 33'(sent_frame_vld), 33'd0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    sent_in = 1'b1;
    repeat (20 * TC) @(negedge clk);
    check_frames("nominal");

    cfg(8'd0, 8'd3, 1'b0);
    send_frame(4'h0, 24'h123456, 4'hD, 56 * TC, 0, 1'b0, -1);
    pause(20);
    check_frames("legacy");

    cfg(8'd0, 8'd3, 1'b1);
    send_frame(4'h0, 24'h123456, 4'h3, 56 * TC, 0, 1'b0, -1);
    pause(20);
    check_frames("crc_bad");

    // D3 of 28 ticks is out of range
    pause(56);
    pulse(56 * TC, 1'b0);
    pulse(12 * TC, 1'b0);
    pulse(13 * TC, 1'b0);
    pulse(14 * TC, 1'b0);
    pulse(28 * TC, 1'b0);
    pause(20);
    exp_err++;
    check_frames("framing");
    send_frame(4'h9, 24'hA5C3F0, crc_ref(24'hA5C3F0, cur_rec), 56 * TC, 0, 1'b1, -1);
    pause(20);
    check_frames("after_framing");

    // Random frames, alternating back-to-back and paused
    for (int k = 0; k < 6; k++) begin
      st = 4'($urandom);
      d  = 24'($urandom);
      c  = (k % 3 == 2) ? 4'($urandom) : crc_ref(d, cur_rec);
      send_frame(st, d, c, 56 * TC + int'($urandom_range(0, TC - 1)) - TC / 2, 0, 1'b1, -1);
      if (k % 2 == 0) pause(int'($urandom_range(13, 40)));
      if (k == 3) pause(100);
    end
    pause(20);
    check_frames("random");
    check("idle_state", 33'(dbg_state), 33'd0);

    // Rounding boundaries: sync 56*TC-TC/2 accepted, one clock less ignored
    send_frame(4'h3, 24'h0F1E2D, crc_ref(24'h0F1E2D, cur_rec), 56 * TC - TC / 2, TC / 2 - 1, 1'b0, -1);
    pause(20);
    check_frames("round_accept");
    send_frame(4'h3, 24'h0F1E2D, crc_ref(24'h0F1E2D, cur_rec), 56 * TC - TC / 2 - 1, 0, 1'b0, -1);
    pause(20);
    check_frames("round_ignore");

    // Line stuck low, then stuck high, mid-frame
    pulse(56 * TC, 1'b0);
    pulse(13 * TC, 1'b0);
    pulse(14 * TC, 1'b0);
    sent_in = 1'b0;
    repeat (1030 * TC) @(negedge clk);
    sent_in = 1'b1;
    repeat (20 * TC) @(negedge clk);
    exp_err++;
    check_frames("stuck_low");
    pulse(56 * TC, 1'b0);
    pulse(13 * TC, 1'b0);
    repeat (1030 * TC) @(negedge clk);
    pause(20);
    exp_err++;
    check_frames("stuck_high");
    send_frame(4'h1, 24'h777777, crc_ref(24'h777777, cur_rec), 56 * TC, 0, 1'b1, -1);
    pause(20);
    check_frames("after_timeout");

    // Matching config mid-DATA drops the frame silently; non-matching is ignored
    sent_config_channel = 8'd0;
    sent_ctick_len = 8'd3;
    sent_crc_mode = 1'b1;
    send_frame(4'h2, 24'h314159, crc_ref(24'h314159, 1'b1), 56 * TC, 0, 1'b0, 4);
    pause(20);
    check_frames("cfg_abort");
    send_frame(4'h4, 24'h271828, crc_ref(24'h271828, cur_rec), 56 * TC, 0, 1'b0, -1);
    pause(20);
    check_frames("after_cfg");
    sent_config_channel = 8'd5;
    sent_ctick_len = 8'd10;
    sent_crc_mode = 1'b0;
    send_frame(4'h6, 24'hC0FFEE, crc_ref(24'hC0FFEE, cur_rec), 56 * TC, 0, 1'b0, 3);
    pause(20);
    check_frames("cfg_other");
    sent_config_channel = 8'd0;
    sent_ctick_len = 8'd3;
    sent_crc_mode = 1'b1;

    // Asynchronous reset mid-frame
    pulse(56 * TC, 1'b0);
    pulse(15 * TC, 1'b0);
    pulse(16 * TC, 1'b0);
    #3 rst = 1'b1;
    cur_rec = 1'b1;
    #1;
    check("arst_vld", 33'(sent_frame_vld), 33'd0);
    check("arst_data", 33'(sent_frame_data), 33'd0);
    check("arst_crc_err", 33'(sent_crc_err), 33'd0);
    check("arst_err", 33'(sent_err), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse(17 * TC, 1'b0);
    pause(20);
    check_frames("arst_drop");
    send_frame(4'hE, 24'hFEDCBA, crc_ref(24'hFEDCBA, cur_rec), 56 * TC, 0, 1'b1, -1);
    pause(20);
    check_frames("after_arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
